// File: rtl/regfile_mp.sv
// Parametrised integer register file: two read ports, one write port, debug port, a0 tap,
// and a clear sequencer that zeroes every entry after reset before accepting writes.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_CLEAR | zero one entry per edge, WE3 ignored, outputs held 0
// S_RUN   | normal operation, reads registered, writes accepted
module regfile_mp #(
   parameter int ADDRESS_WIDTH = 5,
   parameter int DATA_WIDTH    = 32,
   parameter int BYPASS        = 1,
   parameter int A0_INDEX      = 10
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [ADDRESS_WIDTH-1:0] AD1,
   input  logic [ADDRESS_WIDTH-1:0] AD2,
   input  logic [ADDRESS_WIDTH-1:0] AD3,
   input  logic                     WE3,
   input  logic [DATA_WIDTH-1:0]    WD3,
   input  logic [ADDRESS_WIDTH-1:0] DBG_AD,
   output logic [DATA_WIDTH-1:0]    RD1,
   output logic [DATA_WIDTH-1:0]    RD2,
   output logic [DATA_WIDTH-1:0]    a0,
   output logic [DATA_WIDTH-1:0]    DBG_RD,
   output logic                     ready
);

   localparam int DEPTH = 2 ** ADDRESS_WIDTH;

   typedef logic [ADDRESS_WIDTH-1:0] idx_t;
   typedef logic [DATA_WIDTH-1:0]    word_t;
   typedef enum logic {S_CLEAR, S_RUN} state_t;

   localparam idx_t A0_IDX = idx_t'(A0_INDEX);

   state_t state, state_nxt;
   idx_t   clr_cnt;
   word_t  mem [DEPTH];

   logic   run_wr;
   logic   wr_en;
   idx_t   wr_idx;
   word_t  wr_data;
   word_t  rd1_nxt, rd2_nxt, a0_nxt, dbg_nxt;

   // Index 0 is hardwired to zero; bypass only forwards writes that actually land.
   function automatic word_t read_port(input idx_t idx, input word_t stored,
                                       input logic wr, input idx_t widx, input word_t wdata);
      word_t val;
      if (idx == '0)
         val = '0;
      else if ((BYPASS != 0) && wr && (widx == idx))
         val = wdata;
      else
         val = stored;
      return val;
   endfunction

   always_comb begin
      state_nxt = state;
      run_wr    = WE3 && (AD3 != '0) && (state == S_RUN);
      wr_en     = 1'b0;
      wr_idx    = clr_cnt;
      wr_data   = '0;
      case (state)
         S_CLEAR: begin
            wr_en = 1'b1;
            if (clr_cnt == '1)
               state_nxt = S_RUN;
         end
         S_RUN: begin
            wr_en   = run_wr;
            wr_idx  = AD3;
            wr_data = WD3;
         end
         default: state_nxt = S_CLEAR;
      endcase
      rd1_nxt = read_port(AD1, mem[AD1], run_wr, AD3, WD3);
      rd2_nxt = read_port(AD2, mem[AD2], run_wr, AD3, WD3);
      a0_nxt  = read_port(A0_IDX, mem[A0_IDX], run_wr, AD3, WD3);
      dbg_nxt = read_port(DBG_AD, mem[DBG_AD], run_wr, AD3, WD3);
   end

   always_ff @(posedge clk) begin
      if (rst)
         state <= S_CLEAR;
      else
         state <= state_nxt;
   end

   // Storage has no reset of its own; the clear sequencer initialises it.
   always_ff @(posedge clk) begin
      if (!rst && wr_en)
         mem[wr_idx] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         clr_cnt <= '0;
         ready   <= 1'b0;
         RD1     <= '0;
         RD2     <= '0;
         a0      <= '0;
         DBG_RD  <= '0;
      end else begin
         if (state == S_CLEAR)
            clr_cnt <= clr_cnt + 1'b1;
         ready <= (state_nxt == S_RUN);
         if (state == S_RUN) begin
            RD1    <= rd1_nxt;
            RD2    <= rd2_nxt;
            a0     <= a0_nxt;
            DBG_RD <= dbg_nxt;
         end else begin
            RD1    <= '0;
            RD2    <= '0;
            a0     <= '0;
            DBG_RD <= '0;
         end
      end
   end

endmodule
